// File: rtl/vm_pkg.sv
// Shared types and constants for the vending-machine change dispenser:
// coin bus encoding, coin values in cents and the dispenser FSM states.
package vm_pkg;

  typedef enum logic [1:0] {
    COIN_NONE    = 2'd0,
    COIN_NICKEL  = 2'd1,
    COIN_DIME    = 2'd2,
    COIN_QUARTER = 2'd3
  } coin_t;

  localparam int VAL_NICKEL  = 5;
  localparam int VAL_DIME    = 10;
  localparam int VAL_QUARTER = 25;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    EMIT   = 2'd2,
    DONE   = 2'd3
  } chg_state_t;

endpackage

// File: rtl/vm_coin_inventory.sv
// Per-denomination saturating coin counters (index 0=N, 1=D, 2=Q).
// A refill and a dispensed-coin decrement may hit the same counter in one cycle.
module vm_coin_inventory
  import vm_pkg::*;
#(
  parameter int INV_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [1:0]       load_coin,
  input  logic [INV_W-1:0] load_count,
  input  logic             dec_valid,
  input  logic [1:0]       dec_coin,
  output logic [INV_W-1:0] inv_n,
  output logic [INV_W-1:0] inv_d,
  output logic [INV_W-1:0] inv_q
);

  logic [2:0][INV_W-1:0] r_cnt;
  logic [2:0][INV_W-1:0] w_nxt;

  for (genvar g = 0; g < 3; g++) begin : g_cnt
    logic [INV_W-1:0] w_add;
    logic             w_dec;
    logic [INV_W:0]   w_sum;

    assign w_add = (load_valid && load_coin == 2'(g + 1)) ? load_count : '0;
    assign w_dec = dec_valid && dec_coin == 2'(g + 1);
    // Decrement only happens on a non-empty counter, so the sum cannot wrap low.
    assign w_sum = {1'b0, r_cnt[g]} + {1'b0, w_add} - (INV_W+1)'(w_dec);
    assign w_nxt[g] = w_sum[INV_W] ? '1 : w_sum[INV_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= w_nxt;
  end

  assign inv_n = r_cnt[0];
  assign inv_d = r_cnt[1];
  assign inv_q = r_cnt[2];

endmodule

// File: rtl/vm_change_dispenser.sv
// Greedy largest-coin-first change dispenser, one coin per hopper handshake.
// Define VM_CHANGE_INV_EN to enable inventory tracking, refill and inventory-gated selection.
module vm_change_dispenser
  import vm_pkg::*;
#(
  parameter int AMT_W = 8,
  parameter int INV_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chg_valid,
  input  logic [AMT_W-1:0] chg_amt,
  output logic             chg_ready,
  output logic [1:0]       coin_out,
  output logic             coin_valid,
  input  logic             coin_ack,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] short_amt,
  input  logic             load_valid,
  input  logic [1:0]       load_coin,
  input  logic [INV_W-1:0] load_count,
  output logic [INV_W-1:0] inv_n,
  output logic [INV_W-1:0] inv_d,
  output logic [INV_W-1:0] inv_q
);

  localparam logic [AMT_W-1:0] C_VAL_N = AMT_W'(VAL_NICKEL);
  localparam logic [AMT_W-1:0] C_VAL_D = AMT_W'(VAL_DIME);
  localparam logic [AMT_W-1:0] C_VAL_Q = AMT_W'(VAL_QUARTER);

  chg_state_t       r_state, w_next;
  logic [AMT_W-1:0] r_rem;
  coin_t            r_coin;
  logic             r_done, r_short;
  logic [AMT_W-1:0] r_short_amt;

  coin_t            w_pick;
  logic [AMT_W-1:0] w_coin_val;
  logic             w_ack;
  logic             w_has_n, w_has_d, w_has_q;

  assign w_ack = (r_state == EMIT) && coin_ack;

`ifdef VM_CHANGE_INV_EN
  vm_coin_inventory #(.INV_W(INV_W)) u_inv (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_coin  (load_coin),
    .load_count (load_count),
    .dec_valid  (w_ack),
    .dec_coin   (r_coin),
    .inv_n      (inv_n),
    .inv_d      (inv_d),
    .inv_q      (inv_q)
  );
  assign w_has_n = (inv_n != '0);
  assign w_has_d = (inv_d != '0);
  assign w_has_q = (inv_q != '0);
`else
  logic w_unused_load;
  assign w_unused_load = ^{load_valid, load_coin, load_count};
  assign inv_n   = '1;
  assign inv_d   = '1;
  assign inv_q   = '1;
  assign w_has_n = 1'b1;
  assign w_has_d = 1'b1;
  assign w_has_q = 1'b1;
`endif

  // A coin qualifies only if it fits in the remainder, so rem never underflows.
  always_comb begin
    w_pick = COIN_NONE;
    if (w_has_q && r_rem >= C_VAL_Q)      w_pick = COIN_QUARTER;
    else if (w_has_d && r_rem >= C_VAL_D) w_pick = COIN_DIME;
    else if (w_has_n && r_rem >= C_VAL_N) w_pick = COIN_NICKEL;
  end

  always_comb begin
    w_coin_val = '0;
    case (r_coin)
      COIN_NICKEL:  w_coin_val = C_VAL_N;
      COIN_DIME:    w_coin_val = C_VAL_D;
      COIN_QUARTER: w_coin_val = C_VAL_Q;
      default:      w_coin_val = '0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (chg_valid && chg_ready) w_next = SELECT;
      SELECT:  w_next = (w_pick == COIN_NONE) ? DONE : EMIT;
      EMIT:    if (coin_ack) w_next = SELECT;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_coin      <= COIN_NONE;
      r_done      <= 1'b0;
      r_short     <= 1'b0;
      r_short_amt <= '0;
    end else begin
      r_state     <= w_next;
      r_done      <= 1'b0;
      r_short     <= 1'b0;
      r_short_amt <= '0;
      case (r_state)
        IDLE: if (chg_valid) r_rem <= chg_amt;
        SELECT: begin
          if (w_pick != COIN_NONE) begin
            r_coin <= w_pick;
          end else begin
            r_done      <= 1'b1;
            r_short     <= (r_rem != '0);
            r_short_amt <= r_rem;
          end
        end
        EMIT: if (w_ack) r_rem <= r_rem - w_coin_val;
        default: ;
      endcase
    end
  end

  assign chg_ready  = (r_state == IDLE) && !rst;
  assign coin_valid = (r_state == EMIT);
  assign coin_out   = r_coin;
  assign done       = r_done;
  assign short      = r_short;
  assign short_amt  = r_short_amt;

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Directed cycle-exact bench for vm_change_dispenser; inventory scenarios run
// when VM_CHANGE_INV_EN is defined, infinite-inventory scenarios otherwise.
module tb_vm_change_dispenser;

  localparam int AMT_W = 8;
  localparam int INV_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             chg_valid;
  logic [AMT_W-1:0] chg_amt;
  logic             chg_ready;
  logic [1:0]       coin_out;
  logic             coin_valid;
  logic             coin_ack;
  logic             done;
  logic             short;
  logic [AMT_W-1:0] short_amt;
  logic             load_valid;
  logic [1:0]       load_coin;
  logic [INV_W-1:0] load_count;
  logic [INV_W-1:0] inv_n, inv_d, inv_q;

  int errors = 0;
  int checks = 0;

  vm_change_dispenser #(.AMT_W(AMT_W), .INV_W(INV_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .chg_valid  (chg_valid),
    .chg_amt    (chg_amt),
    .chg_ready  (chg_ready),
    .coin_out   (coin_out),
    .coin_valid (coin_valid),
    .coin_ack   (coin_ack),
    .done       (done),
    .short      (short),
    .short_amt  (short_amt),
    .load_valid (load_valid),
    .load_coin  (load_coin),
    .load_count (load_count),
    .inv_n      (inv_n),
    .inv_d      (inv_d),
    .inv_q      (inv_q)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Accept happens on the edge inside this task (E0); returns in SELECT.
  task automatic request(input string tag, input int amt);
    chk({tag, "_ready"}, 32'(chg_ready), 32'd1);
    chg_amt   = AMT_W'(amt);
    chg_valid = 1'b1;
    cyc();
    chg_valid = 1'b0;
    chk({tag, "_sel_novalid"}, 32'(coin_valid), 32'd0);
  endtask

  // From SELECT: next edge enters EMIT, then an immediate ack returns to SELECT.
  task automatic coin(input string tag, input int exp_coin);
    cyc();
    chk({tag, "_valid"}, 32'(coin_valid), 32'd1);
    chk({tag, "_coin"}, 32'(coin_out), 32'(exp_coin));
    coin_ack = 1'b1;
    cyc();
    coin_ack = 1'b0;
    chk({tag, "_acked"}, 32'(coin_valid), 32'd0);
  endtask

  // From SELECT with nothing left to pay: DONE pulse, then back to IDLE.
  task automatic finish(input string tag, input int exp_short, input int exp_amt);
    cyc();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_short"}, 32'(short), 32'(exp_short));
    chk({tag, "_short_amt"}, 32'(short_amt), 32'(exp_amt));
    chk({tag, "_no_coin"}, 32'(coin_valid), 32'd0);
    cyc();
    chk({tag, "_done_low"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(chg_ready), 32'd1);
  endtask

  task automatic load(input int c, input int n);
    load_valid = 1'b1;
    load_coin  = 2'(c);
    load_count = INV_W'(n);
    cyc();
    load_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    rst        = 1'b1;
    chg_valid  = 1'b0;
    chg_amt    = '0;
    coin_ack   = 1'b0;
    load_valid = 1'b0;
    load_coin  = 2'd0;
    load_count = '0;
    cyc();
    cyc();
    chk("rst_ready", 32'(chg_ready), 32'd0);
    chk("rst_cvalid", 32'(coin_valid), 32'd0);
    chk("rst_cout", 32'(coin_out), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_short", 32'(short), 32'd0);
    chk("rst_samt", 32'(short_amt), 32'd0);
`ifdef VM_CHANGE_INV_EN
    chk("rst_inv_n", 32'(inv_n), 32'd0);
    chk("rst_inv_d", 32'(inv_d), 32'd0);
    chk("rst_inv_q", 32'(inv_q), 32'd0);
`else
    chk("rst_inv_n", 32'(inv_n), 32'd63);
    chk("rst_inv_d", 32'(inv_d), 32'd63);
    chk("rst_inv_q", 32'(inv_q), 32'd63);
`endif
    rst = 1'b0;
    cyc();
    chk("post_rst_ready", 32'(chg_ready), 32'd1);

    // Stray ack while idle must not start anything.
    coin_ack = 1'b1;
    cyc();
    coin_ack = 1'b0;
    chk("idle_ack_ready", 32'(chg_ready), 32'd1);
    chk("idle_ack_cvalid", 32'(coin_valid), 32'd0);

`ifdef VM_CHANGE_INV_EN
    // Full inventory, 40c -> Q D N.
    load(1, 63); load(2, 63); load(3, 63);
    chk("full_inv_q", 32'(inv_q), 32'd63);
    request("a40", 40);
    coin("a40_q", 3); coin("a40_d", 2); coin("a40_n", 1);
    finish("a40", 0, 0);
    chk("a40_inv_q", 32'(inv_q), 32'd62);
    chk("a40_inv_d", 32'(inv_d), 32'd62);
    chk("a40_inv_n", 32'(inv_n), 32'd62);

    // No quarters, 30c -> D D D.
    do_reset();
    load(1, 63); load(2, 63);
    request("a30", 30);
    coin("a30_d1", 2); coin("a30_d2", 2); coin("a30_d3", 2);
    finish("a30", 0, 0);
    chk("a30_inv_d", 32'(inv_d), 32'd60);

    // d=0, n=1, q=5, 15c -> N then short 10.
    do_reset();
    load(1, 1); load(3, 5);
    request("a15", 15);
    coin("a15_n", 1);
    finish("a15", 1, 10);
    chk("a15_inv_n", 32'(inv_n), 32'd0);
    chk("a15_inv_q", 32'(inv_q), 32'd5);

    // Refill D while a dime is acked: 30 + 40 - 1 saturates at 63.
    do_reset();
    load(2, 30);
    request("rf", 10);
    cyc();
    chk("rf_coin", 32'(coin_out), 32'd2);
    coin_ack   = 1'b1;
    load_valid = 1'b1;
    load_coin  = 2'd2;
    load_count = INV_W'(40);
    cyc();
    coin_ack   = 1'b0;
    load_valid = 1'b0;
    chk("rf_inv_d", 32'(inv_d), 32'd63);
    finish("rf", 0, 0);
    load(1, 63);
`else
    // Infinite inventory; loads are ignored.
    load(1, 5);
    chk("ld_ignored_n", 32'(inv_n), 32'd63);
    request("a40", 40);
    coin("a40_q", 3); coin("a40_d", 2); coin("a40_n", 1);
    finish("a40", 0, 0);
    request("a30", 30);
    coin("a30_q", 3); coin("a30_n", 1);
    finish("a30", 0, 0);
    request("a3", 3);
    finish("a3", 1, 3);
`endif

    // 7c -> N, short 2.
    request("a7", 7);
    coin("a7_n", 1);
    finish("a7", 1, 2);

    // Zero amount: done after E1, ready after E2.
    request("a0", 0);
    finish("a0", 0, 0);

    // Ack withheld for 5 cycles: coin held stable.
    request("hold", 5);
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(coin_valid), 32'd1);
      chk("hold_coin", 32'(coin_out), 32'd1);
      cyc();
    end
    coin_ack = 1'b1;
    cyc();
    coin_ack = 1'b0;
    finish("hold", 0, 0);

    // Reset during EMIT drops the request without a done.
    request("mid", 5);
    cyc();
    chk("mid_valid", 32'(coin_valid), 32'd1);
    rst = 1'b1;
    cyc();
    chk("mid_rst_cvalid", 32'(coin_valid), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_ready", 32'(chg_ready), 32'd0);
    rst = 1'b0;
    cyc();
    chk("mid_after_ready", 32'(chg_ready), 32'd1);
    chk("mid_after_done", 32'(done), 32'd0);
    cyc();
    chk("mid_after_done2", 32'(done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
